// File: rtl/seq_ctrl_pkg.sv
// ctrl_pkg: sequencer opcodes, state encoding (STALL only under SEQ_STEP_EN) and WAIT_MAX range check
package ctrl_pkg;
  localparam logic [3:0] OP_CLA = 4'd0;
  localparam logic [3:0] OP_COM = 4'd1;
  localparam logic [3:0] OP_SHR = 4'd2;
  localparam logic [3:0] OP_CSL = 4'd3;
  localparam logic [3:0] OP_STOP = 4'd4;
  localparam logic [3:0] OP_ADD = 4'd5;
  localparam logic [3:0] OP_STA = 4'd6;
  localparam logic [3:0] OP_LDA = 4'd7;
  localparam logic [3:0] OP_JMP = 4'd8;
  localparam logic [3:0] OP_BAN = 4'd9;
  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    HALT
`ifdef SEQ_STEP_EN
    , STALL
`endif
  } state_t;
  function automatic bit wait_max_ok(input int unsigned w);
    return w >= 1 && w <= 255;
  endfunction
endpackage

// File: rtl/seq_ctrl_if.sv
// seq_ctrl_if: sequencer-to-datapath/memory strobe bundle (step only under SEQ_STEP_EN)
interface seq_ctrl_if;
  logic [3:0] opIn;
  logic accNeg;
  logic memRdy;
`ifdef SEQ_STEP_EN
  logic step;
`endif
  logic memRd;
  logic memWr;
  logic addrSel;
  logic irWr;
  logic pcInc;
  logic pcLoad;
  logic wrAcc;
  logic [3:0] aluOp;
  logic halted;
  logic busErr;
  modport master (
`ifdef SEQ_STEP_EN
    input step,
`endif
    input opIn, accNeg, memRdy,
    output memRd, memWr, addrSel, irWr, pcInc, pcLoad, wrAcc, aluOp, halted, busErr
  );
  modport slave (
`ifdef SEQ_STEP_EN
    output step,
`endif
    output opIn, accNeg, memRdy,
    input memRd, memWr, addrSel, irWr, pcInc, pcLoad, wrAcc, aluOp, halted, busErr
  );
endinterface

// File: rtl/seq_ctrl_wait_timer.sv
// wait_timer: memory-wait watchdog, expired on the WAIT_MAX-th consecutive enabled cycle
module wait_timer #(
  parameter int unsigned WAIT_MAX = 15
) (
  input logic clk,
  input logic rst,
  input logic clr,
  input logic en,
  output logic expired
);
  logic [7:0] cnt;
  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= 8'd0;
    else if (en) cnt <= cnt + 8'd1;
  end
  assign expired = en && cnt == 8'(WAIT_MAX - 1);
endmodule

// File: rtl/seq_ctrl.sv
// seq_ctrl: multi-cycle accumulator CPU sequencer with memory watchdog; SEQ_STEP_EN adds single-step STALL
module seq_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 15
) (
  input logic clk,
  input logic rst,
  seq_ctrl_if.master bus
);
  if (!wait_max_ok(WAIT_MAX)) begin : g_bad_wait_max
    $error("seq_ctrl: WAIT_MAX must be 1..255");
  end
`ifdef SEQ_STEP_EN
  localparam state_t RET = STALL;
`else
  localparam state_t RET = FETCH;
`endif
  state_t state, nxt;
  logic waiting, expired, bus_err, is_exec, is_mem, alu_en;
  assign waiting = state == FETCH || state == MEM;
  assign is_exec = bus.opIn <= OP_CSL || bus.opIn == OP_JMP || bus.opIn == OP_BAN;
  assign is_mem = bus.opIn == OP_ADD || bus.opIn == OP_STA || bus.opIn == OP_LDA;
  wait_timer #(.WAIT_MAX(WAIT_MAX)) u_timer (
    .clk(clk),
    .rst(rst),
    .clr(!waiting),
    .en(waiting && !bus.memRdy),
    .expired(expired)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      bus_err <= 1'b0;
    end else begin
      state <= nxt;
      bus_err <= bus_err | expired;
    end
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = RET;
      FETCH: nxt = bus.memRdy ? DECODE : expired ? HALT : FETCH;
      DECODE: nxt = bus.opIn == OP_STOP ? HALT : is_mem ? MEM : is_exec ? EXEC : RET;
      EXEC: nxt = RET;
      MEM: nxt = bus.memRdy ? (bus.opIn == OP_STA ? RET : WB) : expired ? HALT : MEM;
      WB: nxt = RET;
`ifdef SEQ_STEP_EN
      STALL: nxt = bus.step ? FETCH : STALL;
`endif
      default: nxt = HALT;
    endcase
  end
  always_comb begin
    alu_en = (state == EXEC && bus.opIn <= OP_CSL) || state == WB;
    bus.memRd = state == FETCH || (state == MEM && (bus.opIn == OP_ADD || bus.opIn == OP_LDA));
    bus.memWr = state == MEM && bus.opIn == OP_STA;
    bus.addrSel = state == MEM;
    bus.irWr = state == FETCH && bus.memRdy;
    bus.pcInc = state == FETCH && bus.memRdy;
    bus.pcLoad = state == EXEC && (bus.opIn == OP_JMP || (bus.opIn == OP_BAN && bus.accNeg));
    bus.wrAcc = alu_en;
    bus.aluOp = alu_en ? bus.opIn : 4'd0;
    bus.halted = state == HALT;
    bus.busErr = bus_err;
  end
endmodule

// File: tb/tb_seq_ctrl.sv
// tb_seq_ctrl: directed self-checking bench for seq_ctrl (default build, WAIT_MAX=15)
module tb_seq_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  localparam logic [12:0] RD = 13'h1000;
  localparam logic [12:0] WR = 13'h0800;
  localparam logic [12:0] AS = 13'h0400;
  localparam logic [12:0] PL = 13'h0080;
  localparam logic [12:0] WA = 13'h0040;
  localparam logic [12:0] HL = 13'h0020;
  localparam logic [12:0] BE = 13'h0010;
  localparam logic [12:0] FE = 13'h1300;
  seq_ctrl_if bus();
  seq_ctrl #(.WAIT_MAX(15)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [12:0] outs();
    return {bus.memRd, bus.memWr, bus.addrSel, bus.irWr, bus.pcInc, bus.pcLoad, bus.wrAcc,
            bus.halted, bus.busErr, bus.aluOp};
  endfunction
  task automatic do_reset();
    rst = 1'b1;
    bus.memRdy = 1'b0;
    bus.opIn = 4'd0;
    bus.accNeg = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    bus.memRdy = 1'b1;
    bus.opIn = 4'd7;
    bus.accNeg = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (outs() !== 13'h0) begin
      errors++;
      $display("FAIL reset: got %h want %h", outs(), 13'h0);
    end
  endtask
  task automatic test_lda();
    logic [12:0] e [6];
    e = '{13'h0, FE, 13'h0, RD | AS, WA | 13'h7, FE};
    do_reset();
    bus.memRdy = 1'b1;
    bus.opIn = 4'd7;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (outs() !== e[i]) begin
        errors++;
        $display("FAIL lda c%0d: got %h want %h", i + 1, outs(), e[i]);
      end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_sta_wait();
    logic [12:0] e [8];
    logic r [8];
    e = '{13'h0, FE, 13'h0, WR | AS, WR | AS, WR | AS, WR | AS, FE};
    r = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    do_reset();
    bus.opIn = 4'd6;
    for (int i = 0; i < 8; i++) begin
      bus.memRdy = r[i];
      @(negedge clk);
      checks++;
      if (outs() !== e[i]) begin
        errors++;
        $display("FAIL sta_wait c%0d: got %h want %h", i + 1, outs(), e[i]);
      end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_branch();
    logic [12:0] e [13];
    logic [3:0] op [13];
    logic a [13];
    e = '{13'h0, FE, 13'h0, 13'h0, FE, 13'h0, PL, FE, 13'h0, PL, FE, 13'h0, PL};
    op = '{4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd8, 4'd8, 4'd8, 4'd8, 4'd8, 4'd8};
    a = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    do_reset();
    bus.memRdy = 1'b1;
    for (int i = 0; i < 13; i++) begin
      bus.opIn = op[i];
      bus.accNeg = a[i];
      @(negedge clk);
      checks++;
      if (outs() !== e[i]) begin
        errors++;
        $display("FAIL branch c%0d: got %h want %h", i + 1, outs(), e[i]);
      end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_alu_nop();
    logic [12:0] e [14];
    logic [3:0] op [14];
    e = '{13'h0, FE, 13'h0, WA | 13'h1, FE, 13'h0, WA | 13'h3, FE, 13'h0, RD | AS, WA | 13'h5,
          FE, 13'h0, FE};
    op = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd3, 4'd3, 4'd3, 4'd5, 4'd5, 4'd5, 4'd5, 4'd12, 4'd12, 4'd12};
    do_reset();
    bus.memRdy = 1'b1;
    for (int i = 0; i < 14; i++) begin
      bus.opIn = op[i];
      @(negedge clk);
      checks++;
      if (outs() !== e[i]) begin
        errors++;
        $display("FAIL alu_nop c%0d: got %h want %h", i + 1, outs(), e[i]);
      end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_stop();
    logic [12:0] e;
    do_reset();
    bus.memRdy = 1'b1;
    bus.opIn = 4'd4;
    for (int i = 0; i < 23; i++) begin
      e = i == 1 ? FE : i >= 3 ? HL : 13'h0;
      @(negedge clk);
      checks++;
      if (outs() !== e) begin
        errors++;
        $display("FAIL stop c%0d: got %h want %h", i + 1, outs(), e);
      end
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (outs() !== 13'h0) begin
      errors++;
      $display("FAIL stop_rst: got %h want %h", outs(), 13'h0);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (outs() !== FE) begin
      errors++;
      $display("FAIL stop_refetch: got %h want %h", outs(), FE);
    end
  endtask
  task automatic test_watchdog();
    logic [12:0] e;
    do_reset();
    for (int i = 0; i < 18; i++) begin
      e = i == 0 ? 13'h0 : i <= 15 ? RD : HL | BE;
      @(negedge clk);
      checks++;
      if (outs() !== e) begin
        errors++;
        $display("FAIL wdog_err c%0d: got %h want %h", i + 1, outs(), e);
      end
      @(posedge clk); #1;
    end
    do_reset();
    bus.opIn = 4'd12;
    for (int i = 0; i < 18; i++) begin
      bus.memRdy = i == 15;
      e = i == 0 ? 13'h0 : i <= 14 ? RD : i == 15 ? FE : i == 16 ? 13'h0 : RD;
      @(negedge clk);
      checks++;
      if (outs() !== e) begin
        errors++;
        $display("FAIL wdog_edge c%0d: got %h want %h", i + 1, outs(), e);
      end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_rst_mid_mem();
    logic [12:0] e [4];
    e = '{13'h0, FE, 13'h0, RD | AS};
    do_reset();
    bus.opIn = 4'd7;
    for (int i = 0; i < 4; i++) begin
      bus.memRdy = i != 3;
      @(negedge clk);
      checks++;
      if (outs() !== e[i]) begin
        errors++;
        $display("FAIL rst_mem c%0d: got %h want %h", i + 1, outs(), e[i]);
      end
      if (i < 3) begin
        @(posedge clk); #1;
      end
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.memRdy = 1'b1;
    @(negedge clk);
    checks++;
    if (outs() !== 13'h0) begin
      errors++;
      $display("FAIL rst_mem_drop: got %h want %h", outs(), 13'h0);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (outs() !== FE) begin
      errors++;
      $display("FAIL rst_mem_refetch: got %h want %h", outs(), FE);
    end
  endtask
  initial begin
    bus.opIn = 4'd0;
    bus.accNeg = 1'b0;
    bus.memRdy = 1'b0;
    test_reset();
    test_lda();
    test_sta_wait();
    test_branch();
    test_alu_nop();
    test_stop();
    test_watchdog();
    test_rst_mid_mem();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
